// File: rtl/slow_clk_mon_pkg.sv
// Shared types and default constants for the slow clock monitor.
package slow_clk_mon_pkg;

    // Measurement FSM state encoding.
    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } mon_state_e;

    // Default parameterisation for the monitor.
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned DEFAULT_CNT_W       = 24;
    localparam int unsigned DEFAULT_TIMEOUT     = 4194304;

endpackage

// File: rtl/slow_clk_monitor_sync_edge.sv
// Synchronizer chain for the asynchronous slow clock plus registered
// rise/fall edge strobes derived from the synchronized level.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d_q;
    logic                   rise_q;
    logic                   fall_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous input directly.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        sync_q[gi] <= 1'b0;
                    end else begin
                        sync_q[gi] <= din_i;
                    end
                end
            end else begin : g_next
                // Later stages resolve metastability from the previous stage.
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        sync_q[gi] <= 1'b0;
                    end else begin
                        sync_q[gi] <= sync_q[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Delayed copy of the level and registered edge strobes; clearing the
    // delayed level in reset keeps strobes quiet in the first cycle after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_d_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            level_d_q <= sync_q[SYNC_STAGES-1];
            rise_q    <= sync_q[SYNC_STAGES-1] & ~level_d_q;
            fall_q    <= ~sync_q[SYNC_STAGES-1] & level_d_q;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/slow_clk_monitor.sv
// Slow clock monitor: synchronizes a slow square wave, strobes its edges,
// measures the period between rising edges and flags a stalled input.
module slow_clk_monitor
    import slow_clk_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             slow_clk,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             rise_w;
    logic             fall_w;
    logic             level_w;

    mon_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic             valid_q,   valid_d;
    logic             stalled_q, stalled_d;
    logic [CNT_W-1:0] cnt_inc;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (slow_clk),
        .level_o(level_w),
        .rise_o (rise_w),
        .fall_o (fall_w)
    );

    // Saturating increment so the counter can never wrap.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);

    // Next-state logic. cnt holds the number of clk cycles since the last
    // rise strobe was consumed, so an interval of exactly TIMEOUT cycles is
    // still published; a stall is declared only once the interval would
    // exceed TIMEOUT. A rise in the same cycle always wins over the stall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = valid_q;
        stalled_d = stalled_q;
        unique case (state_q)
            ACQUIRE: begin
                // First edge only opens a measurement window.
                if (rise_w) begin
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                end
            end
            MEASURE: begin
                if (rise_w) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    cnt_d    = CNT_ONE;
                end else if (cnt_q >= TIMEOUT_C) begin
                    state_d   = STALL;
                    stalled_d = 1'b1;
                    valid_d   = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STALL: begin
                // Recovery edge restarts timing but the gap is not a period.
                if (rise_w) begin
                    state_d   = MEASURE;
                    stalled_d = 1'b0;
                    cnt_d     = CNT_ONE;
                end
            end
            default: begin
                state_d = ACQUIRE;
            end
        endcase
    end

    // State, counter and published-result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ACQUIRE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            stalled_q <= stalled_d;
        end
    end

    assign level        = level_w;
    assign rise         = rise_w;
    assign fall         = fall_w;
    assign period       = period_q;
    assign period_valid = valid_q;
    assign stalled      = stalled_q;

endmodule
